// File: rtl/adc0832_responder.sv
// ADC0832 serial-interface responder: answers a controller's start/SGL/ODD command with a null bit and 8 data bits.
// Optional LSB-first trailer D1..D7 after D0 is enabled by defining ADC0832_LSB_TRAILER_EN.
module adc0832_responder (
  input  logic       clk,
  input  logic       reset,
  input  logic       adc_cs_n,
  input  logic       adc_sclk,
  input  logic       adc_di,
  input  logic [7:0] ch0_value,
  input  logic [7:0] ch1_value,
  output logic       adc_do,
  output logic       adc_do_oe,
  output logic       conv_done,
  output logic [1:0] last_cmd
);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, GET_SGL, GET_ODD, NULL_BIT, MSB_OUT, LSB_OUT, HOLD
  } state_t;

  state_t     r_state, w_state_next;
  logic       r_cs_meta, r_cs_sync, r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic       r_di_meta, r_di_sync;
  logic [1:0] r_fill;
  logic       r_armed;
  logic       r_do, w_do_next, r_oe, w_oe_next, r_done, w_done_next;
  logic [1:0] r_cmd, w_cmd_next;
  logic       r_sgl, w_sgl_next;
  logic [7:0] r_result, w_result_next, w_sample;
  logic [3:0] r_bit_cnt, w_bit_cnt_next;
  logic [2:0] w_msb_idx;
  logic       w_sclk_rise, w_sclk_fall;

  assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
  assign w_msb_idx   = 3'(4'd7 - r_bit_cnt);

  assign adc_do    = r_do;
  assign adc_do_oe = r_oe;
  assign conv_done = r_done;
  assign last_cmd  = r_cmd;

  // Conversion value for the command whose ODD bit is on di right now.
  always_comb begin
    w_sample = 8'h00;
    case ({r_sgl, r_di_sync})
      2'b10:   w_sample = ch0_value;
      2'b11:   w_sample = ch1_value;
      2'b00:   w_sample = (ch0_value >= ch1_value) ? (ch0_value - ch1_value) : 8'h00;
      default: w_sample = (ch1_value >= ch0_value) ? (ch1_value - ch0_value) : 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_di_meta   <= 1'b0;
      r_di_sync   <= 1'b0;
      r_fill      <= 2'd0;
      r_armed     <= 1'b0;
      r_state     <= IDLE;
      r_do        <= 1'b0;
      r_oe        <= 1'b0;
      r_done      <= 1'b0;
      r_cmd       <= 2'b00;
      r_sgl       <= 1'b0;
      r_result    <= 8'h00;
      r_bit_cnt   <= 4'd0;
    end else begin
      r_cs_meta   <= adc_cs_n;
      r_cs_sync   <= r_cs_meta;
      r_sclk_meta <= adc_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_di_meta   <= adc_di;
      r_di_sync   <= r_di_meta;
      // cs_n only counts as seen high once the reset values have left the synchronizer.
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd2 && r_cs_sync) r_armed <= 1'b1;
      r_state     <= w_state_next;
      r_do        <= w_do_next;
      r_oe        <= w_oe_next;
      r_done      <= w_done_next;
      r_cmd       <= w_cmd_next;
      r_sgl       <= w_sgl_next;
      r_result    <= w_result_next;
      r_bit_cnt   <= w_bit_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_do_next      = r_do;
    w_oe_next      = r_oe;
    w_done_next    = 1'b0;
    w_cmd_next     = r_cmd;
    w_sgl_next     = r_sgl;
    w_result_next  = r_result;
    w_bit_cnt_next = r_bit_cnt;
    if (r_cs_sync) begin
      w_state_next = IDLE;
      w_do_next    = 1'b0;
      w_oe_next    = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_do_next = 1'b0;
          w_oe_next = 1'b0;
          if (r_armed) w_state_next = WAIT_START;
        end
        WAIT_START: if (w_sclk_rise && r_di_sync) w_state_next = GET_SGL;
        GET_SGL: if (w_sclk_rise) begin
          w_sgl_next   = r_di_sync;
          w_state_next = GET_ODD;
        end
        GET_ODD: if (w_sclk_rise) begin
          w_cmd_next    = {r_sgl, r_di_sync};
          w_result_next = w_sample;
          w_state_next  = NULL_BIT;
        end
        NULL_BIT: if (w_sclk_fall) begin
          w_oe_next      = 1'b1;
          w_do_next      = 1'b0;
          w_bit_cnt_next = 4'd0;
          w_state_next   = MSB_OUT;
        end
        MSB_OUT: if (w_sclk_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_oe_next    = 1'b0;
            w_do_next    = 1'b0;
            w_state_next = HOLD;
          end else begin
            w_do_next      = r_result[w_msb_idx];
            w_bit_cnt_next = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
`ifdef ADC0832_LSB_TRAILER_EN
              w_bit_cnt_next = 4'd1;
              w_state_next   = LSB_OUT;
`else
              w_done_next    = 1'b1;
`endif
            end
          end
        end
        LSB_OUT: if (w_sclk_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_oe_next    = 1'b0;
            w_do_next    = 1'b0;
            w_state_next = HOLD;
          end else begin
            w_do_next      = r_result[r_bit_cnt[2:0]];
            w_bit_cnt_next = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) w_done_next = 1'b1;
          end
        end
        default: begin
          w_oe_next = 1'b0;
          w_do_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc0832_responder.sv
// Directed bench for adc0832_responder: drives controller frames and checks the serial response bit by bit.
module tb_adc0832_responder;

  logic       clk = 1'b0;
  logic       reset, adc_cs_n, adc_sclk, adc_di;
  logic [7:0] ch0_value, ch1_value;
  logic       adc_do, adc_do_oe, conv_done;
  logic [1:0] last_cmd;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  adc0832_responder dut (
    .clk       (clk),
    .reset     (reset),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .adc_di    (adc_di),
    .ch0_value (ch0_value),
    .ch1_value (ch1_value),
    .adc_do    (adc_do),
    .adc_do_oe (adc_do_oe),
    .conv_done (conv_done),
    .last_cmd  (last_cmd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (conv_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_pulse(input logic d);
    adc_di = d;
    wait_n(2);
    adc_sclk = 1'b1;
    wait_n(8);
    adc_sclk = 1'b0;
    wait_n(8);
  endtask

  task automatic frame(input string tag, input int pre_zeros, input logic sgl, input logic odd,
                       input logic [7:0] exp, input int abort_at, input logic use_reset);
    int         start;
    logic [7:0] s0, s1;
    logic       stop;
    stop = 1'b0;
    adc_cs_n = 1'b0;
    wait_n(4);
    start = done_cnt;
    repeat (pre_zeros) sclk_pulse(1'b0);
    sclk_pulse(1'b1);
    sclk_pulse(sgl);
    sclk_pulse(odd);
    // Channel changes after the ODD capture must not reach this frame.
    s0 = ch0_value;
    s1 = ch1_value;
    ch0_value = ~s0;
    ch1_value = ~s1;
    check({tag, "_null"}, 32'({adc_do_oe, adc_do}), 32'b10);
    for (int i = 7; i >= 0 && !stop; i--) begin
      if (i == 0) check({tag, "_early_done"}, 32'(done_cnt), 32'(start));
      sclk_pulse(1'b0);
      check($sformatf("%s_d%0d", tag, i), 32'({adc_do_oe, adc_do}), 32'({1'b1, exp[i]}));
      if (i == abort_at) begin
        stop = 1'b1;
        if (use_reset) begin
          reset = 1'b1;
          wait_n(2);
          reset = 1'b0;
          wait_n(1);
          check({tag, "_rst_out"}, 32'({adc_do_oe, adc_do, conv_done, last_cmd}), 32'd0);
          for (int k = 0; k < 5; k++) begin
            sclk_pulse(k < 2);
            check($sformatf("%s_rst_quiet%0d", tag, k), 32'(adc_do_oe), 32'd0);
          end
        end else begin
          adc_cs_n = 1'b1;
          wait_n(3);
          check({tag, "_abort_oe"}, 32'({adc_do_oe, adc_do}), 32'd0);
          wait_n(4);
          check({tag, "_abort_nodone"}, 32'(done_cnt), 32'(start));
        end
      end
    end
`ifdef ADC0832_LSB_TRAILER_EN
    for (int i = 1; i <= 7 && !stop; i++) begin
      if (i == 7) check({tag, "_early_done_t"}, 32'(done_cnt), 32'(start));
      sclk_pulse(1'b0);
      check($sformatf("%s_t%0d", tag, i), 32'({adc_do_oe, adc_do}), 32'({1'b1, exp[i]}));
    end
`endif
    if (!stop) begin
      check({tag, "_done_once"}, 32'(done_cnt), 32'(start + 1));
      sclk_pulse(1'b0);
      check({tag, "_release"}, 32'({adc_do_oe, adc_do}), 32'd0);
      sclk_pulse(1'b1);
      check({tag, "_hold"}, 32'({adc_do_oe, adc_do}), 32'd0);
    end
    adc_cs_n = 1'b1;
    wait_n(6);
    if (!use_reset) check({tag, "_last_cmd"}, 32'(last_cmd), 32'({sgl, odd}));
    check({tag, "_idle_oe"}, 32'(adc_do_oe), 32'd0);
    ch0_value = s0;
    ch1_value = s1;
  endtask

  initial begin
    reset     = 1'b1;
    adc_cs_n  = 1'b1;
    adc_sclk  = 1'b0;
    adc_di    = 1'b0;
    ch0_value = 8'h00;
    ch1_value = 8'h00;
    wait_n(3);
    reset = 1'b0;
    wait_n(1);
    check("reset_outputs", 32'({adc_do_oe, adc_do, conv_done, last_cmd}), 32'd0);
    wait_n(4);

    ch0_value = 8'hAA;
    frame("c1", 0, 1'b1, 1'b0, 8'hAA, -1, 1'b0);
    ch1_value = 8'h35;
    frame("c2", 0, 1'b1, 1'b1, 8'h35, -1, 1'b0);
    ch0_value = 8'h20;
    ch1_value = 8'h50;
    frame("c3a", 0, 1'b0, 1'b0, 8'h00, -1, 1'b0);
    frame("c3b", 0, 1'b0, 1'b1, 8'h30, -1, 1'b0);
    ch0_value = 8'hAA;
    frame("c4", 3, 1'b1, 1'b0, 8'hAA, -1, 1'b0);
    frame("c5", 0, 1'b1, 1'b0, 8'hAA, 4, 1'b0);
    ch1_value = 8'h35;
    frame("c5n", 0, 1'b1, 1'b1, 8'h35, -1, 1'b0);
    frame("c6", 0, 1'b1, 1'b0, 8'hAA, 5, 1'b1);
    frame("c6n", 0, 1'b1, 1'b0, 8'hAA, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc0832_responder.md
ADC0832_RESPONDER -- requirements
Module: adc0832_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port adc_cs_n, input, 1 bit: chip select from the ADC controller, active low, asynchronous to clk.
REQ-004 SHALL have port adc_sclk, input, 1 bit: serial clock from the controller, asynchronous to clk.
REQ-005 SHALL have port adc_di, input, 1 bit: command bits from the controller.
REQ-006 SHALL have port ch0_value, input, 8 bits: analog value presented on CH0.
REQ-007 SHALL have port ch1_value, input, 8 bits: analog value presented on CH1.
REQ-008 SHALL have port adc_do, output, 1 bit: serial conversion data; reads 0 when not driven.
REQ-009 SHALL have port adc_do_oe, output, 1 bit: high while adc_do is driven (tri-state enable).
REQ-010 SHALL have port conv_done, output, 1 bit: one-cycle pulse when the last data bit has been shifted out.
REQ-011 SHALL have port last_cmd, output, 2 bits: {SGL, ODD} of the most recent accepted command.

Function
REQ-012 SHALL pass adc_cs_n, adc_sclk and adc_di through 2-flop synchronizers and detect sclk rise/fall from the synchronized signal.
REQ-013 SHALL update adc_do/adc_do_oe no later than 4 clk cycles after an adc_sclk falling edge; the controller guarantees sclk high/low phases of at least 6 clk cycles.
REQ-014 SHALL implement states IDLE, WAIT_START, GET_SGL, GET_ODD, NULL_BIT, MSB_OUT, LSB_OUT, HOLD.
REQ-015 SHALL go IDLE->WAIT_START when synchronized cs_n is low.
REQ-016 SHALL stay in WAIT_START while di=0 on sclk rises; the first di=1 on an sclk rise is the start bit and moves to GET_SGL.
REQ-017 SHALL capture SGL on the next sclk rise (->GET_ODD) and ODD on the following rise (->NULL_BIT).
REQ-018 SHALL latch the 8-bit result when ODD is captured: SGL=1,ODD=0 -> ch0_value; SGL=1,ODD=1 -> ch1_value; SGL=0,ODD=0 -> ch0-ch1 clamped at 0; SGL=0,ODD=1 -> ch1-ch0 clamped at 0.
REQ-019 SHALL, on the first sclk fall in NULL_BIT, assert adc_do_oe with adc_do=0, then move to MSB_OUT.
REQ-020 SHALL drive D7..D0 on the next 8 sclk falls in MSB_OUT, using a 4-bit bit counter.
REQ-021 SHALL, after D0, follow REQ-031/REQ-032, then enter HOLD with adc_do_oe=0 and adc_do=0.
REQ-022 SHALL pulse conv_done for one cycle when the final data bit is driven.
REQ-023 SHALL ignore sclk edges in HOLD until cs_n goes high.
REQ-024 SHALL abort any state to IDLE with adc_do_oe=0 within 3 cycles of synchronized cs_n going high, without a conv_done pulse.
REQ-025 SHALL sample channel inputs only at the ODD capture, so later changes do not affect the current frame.
REQ-026 SHALL treat a simultaneous cs_n rise and sclk edge as a cs_n rise, with abort taking priority.

Reset
REQ-027 SHALL, with reset high on a clk edge, force state IDLE, adc_do=0, adc_do_oe=0, conv_done=0, last_cmd=2'b00, and clear bit counter, shift register and synchronizers to idle levels (cs_n=1, sclk=0, di=0).
REQ-028 SHALL, if reset is asserted mid-frame, wait in IDLE until cs_n has been seen high before accepting a new start bit.
REQ-029 SHALL leave reset on the first cycle after reset deasserts.

Configuration
REQ-030 SHALL use macro ADC0832_LSB_TRAILER_EN.
REQ-031 SHALL, when the macro is defined, shift out D1..D7 LSB-first in LSB_OUT on the 7 sclk falls after D0, with conv_done on D7 and release on the next fall.
REQ-032 SHALL, when the macro is undefined, omit LSB_OUT, pulse conv_done on D0 and release adc_do_oe on the next sclk fall.

Verification
REQ-033 Case 1: ch0=8'hAA, cmd start,1,0 -> DO 0,1,0,1,0,1,0,1,0; conv_done once; last_cmd=2'b10.
REQ-034 Case 2: ch1=8'h35, cmd start,1,1 with trailer EN -> MSB 00110101 then LSB trailer 0,1,0,1,1,0,0; adc_do_oe low afterwards.
REQ-035 Case 3: differential ch0=8'h20, ch1=8'h50 -> cmd 0,0 returns 8'h00 and cmd 0,1 returns 8'h30.
REQ-036 Case 4: three di=0 clocks before the start bit -> frame identical to Case 1.
REQ-037 Case 5: cs_n high after D4 -> adc_do_oe=0 within 3 cycles, no conv_done; next frame correct.
REQ-038 Case 6: reset during MSB_OUT with cs_n held low -> outputs at reset values, no response until cs_n has been seen high and then low again.
